// File: rtl/core_pkg.sv
// Shared definitions for the issue controller: register index width, instruction
// class bit positions, FSM states and the per-class operand/unit decode.
package core_pkg;

  localparam int REG_W = 5;
  localparam int CLS_W = 6;

  // Bit positions inside the one-hot class vector assembled by the controller.
  localparam int CIDX_ALU   = 0;
  localparam int CIDX_BR    = 1;
  localparam int CIDX_LOAD  = 2;
  localparam int CIDX_STORE = 3;
  localparam int CIDX_FPU   = 4;
  localparam int CIDX_IO    = 5;

  typedef logic [CLS_W-1:0] cls_vec_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
    logic long_op;
    logic alu_unit;
    logic lsu_unit;
    logic fpu_unit;
    logic io_unit;
  } cls_info_t;

  function automatic cls_info_t cls_decode(input cls_vec_t c);
    cls_info_t info;
    info.use_rs1  = c[CIDX_ALU] | c[CIDX_BR] | c[CIDX_LOAD] | c[CIDX_STORE] | c[CIDX_FPU];
    info.use_rs2  = c[CIDX_ALU] | c[CIDX_BR] | c[CIDX_STORE] | c[CIDX_FPU];
    info.use_rd   = c[CIDX_ALU] | c[CIDX_LOAD] | c[CIDX_FPU];
    info.long_op  = c[CIDX_LOAD] | c[CIDX_FPU];
    info.alu_unit = c[CIDX_ALU] | c[CIDX_BR];
    info.lsu_unit = c[CIDX_LOAD] | c[CIDX_STORE];
    info.fpu_unit = c[CIDX_FPU];
    info.io_unit  = c[CIDX_IO];
    return info;
  endfunction

endpackage

// File: rtl/core_scoreboard.sv
// One register file's busy vector: set on long-op issue, clear on writeback,
// with a same-cycle writeback bypass on the three lookup ports.
module core_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_idx_i,
  input  logic [REG_W-1:0] rs1_idx_i,
  input  logic [REG_W-1:0] rs2_idx_i,
  input  logic [REG_W-1:0] rd_idx_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             rd_busy_o,
  output logic             clr_hit_o
);

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // A register being written back this cycle is already free for the consumer.
  assign rs1_busy_o = sb_q[rs1_idx_i] && !(clr_en_i && clr_idx_i == rs1_idx_i)
                      && !(ZERO_REG && rs1_idx_i == '0);
  assign rs2_busy_o = sb_q[rs2_idx_i] && !(clr_en_i && clr_idx_i == rs2_idx_i)
                      && !(ZERO_REG && rs2_idx_i == '0);
  assign rd_busy_o  = sb_q[rd_idx_i] && !(clr_en_i && clr_idx_i == rd_idx_i)
                      && !(ZERO_REG && rd_idx_i == '0);
  assign clr_hit_o  = sb_q[clr_idx_i];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i && !(ZERO_REG && set_idx_i == '0)) set_mask[set_idx_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_idx_i] = 1'b1;
    sb_d = (sb_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: this is a flop vector, not a RAM, so it is reset; a stale busy bit would wedge decode.
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

endmodule

// File: rtl/core_issue_ctrl.sv
// Issue controller between decode and the execution units: scoreboard hazard stalls,
// outstanding long-op accounting, IO serialization by draining, and flush handling.
module core_issue_ctrl
  import core_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_OUT  = 4,
  parameter int CNT_W    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DEC_VALID,
  output logic             DEC_READY,
  input  logic [REG_W-1:0] RD_NUM,
  input  logic [REG_W-1:0] RS1_NUM,
  input  logic [REG_W-1:0] RS2_NUM,
  input  logic             RD_FP,
  input  logic             RS1_FP,
  input  logic             RS2_FP,
  input  logic             CLS_ALU,
  input  logic             CLS_BR,
  input  logic             CLS_LOAD,
  input  logic             CLS_STORE,
  input  logic             CLS_FPU,
  input  logic             CLS_IO,
  input  logic             LSU_READY,
  input  logic             FPU_READY,
  input  logic             WB_VALID,
  input  logic [REG_W-1:0] WB_RD,
  input  logic             WB_FP,
  input  logic             FLUSH,
  output logic             ISSUE_ALU,
  output logic             ISSUE_LSU,
  output logic             ISSUE_FPU,
  output logic             ISSUE_IO,
  output logic [REG_W-1:0] ISSUE_RD,
  output logic [CNT_W-1:0] OUT_CNT,
  output logic             ERR
);

  cls_vec_t  cls;
  cls_info_t info;

  state_e state_q, state_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             err_q, err_d;
  logic             issue_alu_q, issue_lsu_q, issue_fpu_q, issue_io_q;
  logic [REG_W-1:0] issue_rd_q;

  logic int_rs1_busy, int_rs2_busy, int_rd_busy, int_clr_hit;
  logic fp_rs1_busy, fp_rs2_busy, fp_rd_busy, fp_clr_hit;
  logic rs1_busy, rs2_busy, rd_busy;
  logic hazard, unit_ok, cnt_full, accept, sb_set, cnt_inc, cnt_dec, wb_nonbusy;

  assign cls  = {CLS_IO, CLS_FPU, CLS_STORE, CLS_LOAD, CLS_BR, CLS_ALU};
  assign info = cls_decode(cls);

  assign sb_set = accept && info.long_op;

  core_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(1'b1)) u_int_sb (
    .clk_i      (CLK),
    .rst_i      (RST),
    .set_en_i   (sb_set && !RD_FP),
    .set_idx_i  (RD_NUM),
    .clr_en_i   (WB_VALID && !WB_FP),
    .clr_idx_i  (WB_RD),
    .rs1_idx_i  (RS1_NUM),
    .rs2_idx_i  (RS2_NUM),
    .rd_idx_i   (RD_NUM),
    .rs1_busy_o (int_rs1_busy),
    .rs2_busy_o (int_rs2_busy),
    .rd_busy_o  (int_rd_busy),
    .clr_hit_o  (int_clr_hit)
  );

  core_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(1'b0)) u_fp_sb (
    .clk_i      (CLK),
    .rst_i      (RST),
    .set_en_i   (sb_set && RD_FP),
    .set_idx_i  (RD_NUM),
    .clr_en_i   (WB_VALID && WB_FP),
    .clr_idx_i  (WB_RD),
    .rs1_idx_i  (RS1_NUM),
    .rs2_idx_i  (RS2_NUM),
    .rd_idx_i   (RD_NUM),
    .rs1_busy_o (fp_rs1_busy),
    .rs2_busy_o (fp_rs2_busy),
    .rd_busy_o  (fp_rd_busy),
    .clr_hit_o  (fp_clr_hit)
  );

  assign rs1_busy = RS1_FP ? fp_rs1_busy : int_rs1_busy;
  assign rs2_busy = RS2_FP ? fp_rs2_busy : int_rs2_busy;
  assign rd_busy  = RD_FP  ? fp_rd_busy  : int_rd_busy;

  assign hazard   = (info.use_rs1 && rs1_busy) || (info.use_rs2 && rs2_busy)
                    || (info.use_rd && rd_busy);
  assign unit_ok  = info.lsu_unit ? LSU_READY : (info.fpu_unit ? FPU_READY : 1'b1);
  assign cnt_full = (out_cnt_q == CNT_W'(MAX_OUT));

  always_comb begin
    state_d   = state_q;
    DEC_READY = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        DEC_READY = !FLUSH && !hazard && unit_ok && !(info.long_op && cnt_full)
                    && !info.io_unit;
        if (!FLUSH && DEC_VALID && info.io_unit) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        DEC_READY = (out_cnt_q == '0) && !FLUSH;
        if (FLUSH)                       state_d = ST_RUN;
        else if (DEC_VALID && DEC_READY) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign accept = DEC_VALID && DEC_READY;

  // x0 loads carry no scoreboard bit, so an int x0 writeback is not treated as stray.
  assign cnt_inc    = sb_set;
  assign cnt_dec    = WB_VALID && (out_cnt_q != '0);
  assign wb_nonbusy = WB_FP ? !fp_clr_hit : (!int_clr_hit && (WB_RD != '0));

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (cnt_inc && !cnt_dec)      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (!cnt_inc && cnt_dec) out_cnt_d = out_cnt_q - CNT_W'(1);
    err_d = err_q | (WB_VALID && ((out_cnt_q == '0) || wb_nonbusy));
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (RST) begin
      state_q     <= ST_RUN;
      out_cnt_q   <= '0;
      err_q       <= 1'b0;
      issue_alu_q <= 1'b0;
      issue_lsu_q <= 1'b0;
      issue_fpu_q <= 1'b0;
      issue_io_q  <= 1'b0;
      issue_rd_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_cnt_q   <= out_cnt_d;
      err_q       <= err_d;
      issue_alu_q <= accept && info.alu_unit;
      issue_lsu_q <= accept && info.lsu_unit;
      issue_fpu_q <= accept && info.fpu_unit;
      issue_io_q  <= accept && info.io_unit;
      if (accept) issue_rd_q <= RD_NUM;
    end
  end

  assign ISSUE_ALU = issue_alu_q;
  assign ISSUE_LSU = issue_lsu_q;
  assign ISSUE_FPU = issue_fpu_q;
  assign ISSUE_IO  = issue_io_q;
  assign ISSUE_RD  = issue_rd_q;
  assign OUT_CNT   = out_cnt_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Bench for core_issue_ctrl: directed hazard/drain/flush/error scenarios followed by
// randomized traffic, all checked against a register-array reference model.
module tb_core_issue_ctrl;

  localparam int K_ALU = 0, K_BR = 1, K_LOAD = 2, K_STORE = 3, K_FPU = 4, K_IO = 5;
  localparam int MAXO = 4;

  logic       CLK = 1'b0;
  logic       RST, DEC_VALID, DEC_READY;
  logic [4:0] RD_NUM, RS1_NUM, RS2_NUM;
  logic       RD_FP, RS1_FP, RS2_FP;
  logic       CLS_ALU, CLS_BR, CLS_LOAD, CLS_STORE, CLS_FPU, CLS_IO;
  logic       LSU_READY, FPU_READY, WB_VALID, WB_FP, FLUSH;
  logic [4:0] WB_RD;
  logic       ISSUE_ALU, ISSUE_LSU, ISSUE_FPU, ISSUE_IO;
  logic [4:0] ISSUE_RD;
  logic [2:0] OUT_CNT;
  logic       ERR;

  always #5 CLK = ~CLK;

  core_issue_ctrl #(.NUM_REGS(32), .MAX_OUT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY),
    .RD_NUM(RD_NUM), .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM),
    .RD_FP(RD_FP), .RS1_FP(RS1_FP), .RS2_FP(RS2_FP),
    .CLS_ALU(CLS_ALU), .CLS_BR(CLS_BR), .CLS_LOAD(CLS_LOAD), .CLS_STORE(CLS_STORE),
    .CLS_FPU(CLS_FPU), .CLS_IO(CLS_IO), .LSU_READY(LSU_READY), .FPU_READY(FPU_READY),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_FP(WB_FP), .FLUSH(FLUSH),
    .ISSUE_ALU(ISSUE_ALU), .ISSUE_LSU(ISSUE_LSU), .ISSUE_FPU(ISSUE_FPU), .ISSUE_IO(ISSUE_IO),
    .ISSUE_RD(ISSUE_RD), .OUT_CNT(OUT_CNT), .ERR(ERR)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-file busy flags, a list of outstanding writebacks, drain flag.
  typedef struct { bit fp; bit [4:0] rd; } ent_t;
  bit   m_int [32];
  bit   m_fp  [32];
  ent_t m_q[$];
  int   m_cnt;
  bit   m_drain, m_err;
  bit [3:0] m_issue;
  bit [4:0] m_rd;

  function automatic bit m_busy(input bit fp, input bit [4:0] n);
    bit b;
    if (!fp && n == 0) return 1'b0;
    b = fp ? m_fp[n] : m_int[n];
    if (WB_VALID && WB_FP == fp && WB_RD == n) b = 1'b0;
    return b;
  endfunction

  function automatic bit m_ready();
    bit haz;
    if (m_drain) return (m_cnt == 0) && !FLUSH;
    if (FLUSH || CLS_IO) return 1'b0;
    haz = m_busy(RS1_FP, RS1_NUM);
    if (CLS_ALU || CLS_BR || CLS_STORE || CLS_FPU) haz |= m_busy(RS2_FP, RS2_NUM);
    if (CLS_ALU || CLS_LOAD || CLS_FPU)            haz |= m_busy(RD_FP, RD_NUM);
    if ((CLS_LOAD || CLS_STORE) && !LSU_READY) return 1'b0;
    if (CLS_FPU && !FPU_READY) return 1'b0;
    if ((CLS_LOAD || CLS_FPU) && m_cnt == MAXO) return 1'b0;
    return !haz;
  endfunction

  task automatic m_step(input bit r);
    bit acc, nb;
    if (RST) begin
      foreach (m_int[i]) begin m_int[i] = 0; m_fp[i] = 0; end
      m_q.delete();
      m_cnt = 0; m_drain = 0; m_err = 0; m_issue = '0; m_rd = '0;
      return;
    end
    acc = DEC_VALID && r;
    m_issue = {acc && CLS_IO, acc && CLS_FPU, acc && (CLS_LOAD || CLS_STORE),
               acc && (CLS_ALU || CLS_BR)};
    if (acc) m_rd = RD_NUM;
    if (WB_VALID) begin
      nb = WB_FP ? !m_fp[WB_RD] : (!m_int[WB_RD] && WB_RD != 0);
      if (m_cnt == 0 || nb) m_err = 1;
      if (WB_FP) m_fp[WB_RD] = 0; else m_int[WB_RD] = 0;
      if (m_cnt > 0) m_cnt--;
      foreach (m_q[i]) if (m_q[i].fp == WB_FP && m_q[i].rd == WB_RD) begin
        m_q.delete(i);
        break;
      end
    end
    if (acc && (CLS_LOAD || CLS_FPU)) begin
      if (RD_FP) m_fp[RD_NUM] = 1; else if (RD_NUM != 0) m_int[RD_NUM] = 1;
      m_cnt++;
      m_q.push_back('{fp: RD_FP, rd: RD_NUM});
    end
    if (FLUSH)                               m_drain = 0;
    else if (!m_drain && DEC_VALID && CLS_IO) m_drain = 1;
    else if (m_drain && acc)                 m_drain = 0;
  endtask

  // Inputs are already set; check the combinational ready, clock once, check registers.
  task automatic tick();
    bit r;
    #1;
    r = 1'b0;
    if (!RST) begin
      r = m_ready();
      check("dec_ready", DEC_READY, r);
    end
    m_step(r);
    @(posedge CLK);
    #1;
    check("issue_vec", {ISSUE_IO, ISSUE_FPU, ISSUE_LSU, ISSUE_ALU}, m_issue);
    if (m_issue != 0) check("issue_rd", ISSUE_RD, m_rd);
    check("out_cnt", OUT_CNT, m_cnt);
    check("err", ERR, m_err);
  endtask

  task automatic op(input int k, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                    input bit rdf = 0, input bit r1f = 0, input bit r2f = 0);
    DEC_VALID = 1; RD_NUM = rd; RS1_NUM = rs1; RS2_NUM = rs2;
    RD_FP = rdf; RS1_FP = r1f; RS2_FP = r2f;
    {CLS_IO, CLS_FPU, CLS_STORE, CLS_LOAD, CLS_BR, CLS_ALU} = 6'(1 << k);
  endtask

  task automatic idle();
    DEC_VALID = 0; RD_NUM = 0; RS1_NUM = 0; RS2_NUM = 0; RD_FP = 0; RS1_FP = 0; RS2_FP = 0;
    {CLS_IO, CLS_FPU, CLS_STORE, CLS_LOAD, CLS_BR, CLS_ALU} = '0;
  endtask

  task automatic wb(input bit fp, input bit [4:0] rd);
    WB_VALID = 1; WB_FP = fp; WB_RD = rd;
  endtask

  task automatic nowb();
    WB_VALID = 0; WB_FP = 0; WB_RD = 0;
  endtask

  task automatic do_reset();
    RST = 1; idle(); nowb(); FLUSH = 0;
    tick(); tick();
    RST = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    LSU_READY = 1; FPU_READY = 1;
    do_reset();
    check("rst_out_cnt", OUT_CNT, 0);
    check("rst_err", ERR, 0);
    check("rst_issue", {ISSUE_IO, ISSUE_FPU, ISSUE_LSU, ISSUE_ALU}, 0);

    // Load x5 then dependent ADD; release via same-cycle writeback bypass.
    op(K_LOAD, 5, 1, 0); tick();
    check("t1_issue_lsu", ISSUE_LSU, 1);
    op(K_ALU, 6, 5, 1); #1 check("t1_raw_stall", DEC_READY, 0);
    tick(); tick();
    wb(0, 5); #1 check("t1_bypass_ready", DEC_READY, 1);
    tick(); nowb(); idle();
    check("t1_issue_alu", ISSUE_ALU, 1);
    check("t1_issue_rd", ISSUE_RD, 6);

    // FPU f3 then FLW f3: WAW in the FP file, not released by an int x3 writeback.
    op(K_LOAD, 3, 1, 0); tick();
    op(K_FPU, 3, 1, 2, 1, 1, 1); tick();
    op(K_LOAD, 3, 2, 0, 1, 0, 0); #1 check("t2_waw_stall", DEC_READY, 0);
    tick();
    wb(0, 3); #1 check("t2_int_wb_no_release", DEC_READY, 0);
    tick();
    wb(1, 3); #1 check("t2_fp_wb_release", DEC_READY, 1);
    tick(); idle();
    check("t2_issue_lsu", ISSUE_LSU, 1);
    wb(1, 3); tick(); nowb();
    check("t2_cnt_zero", OUT_CNT, 0);

    // Outstanding limit.
    for (int i = 0; i < 4; i++) begin op(K_LOAD, 5'(10 + i), 1, 0); tick(); end
    check("t3_cnt_full", OUT_CNT, 4);
    op(K_LOAD, 14, 1, 0); #1 check("t3_fifth_stall", DEC_READY, 0);
    tick();
    wb(0, 10); #1 check("t3_stall_in_wb_cycle", DEC_READY, 0);
    tick(); nowb();
    check("t3_cnt_three", OUT_CNT, 3);
    #1 check("t3_fifth_ready", DEC_READY, 1);
    tick(); idle();
    check("t3_fifth_issue", ISSUE_LSU, 1);
    for (int i = 11; i <= 14; i++) begin wb(0, 5'(i)); tick(); end
    nowb();

    // IO serialization by draining.
    op(K_LOAD, 20, 1, 0); tick();
    op(K_LOAD, 21, 1, 0); tick();
    check("t4_cnt_two", OUT_CNT, 2);
    op(K_IO, 0, 0, 0); #1 check("t4_io_not_in_run", DEC_READY, 0);
    tick(); tick();
    wb(0, 20); tick();
    wb(0, 21); #1 check("t4_drain_wait", DEC_READY, 0);
    tick(); nowb();
    #1 check("t4_drain_ready", DEC_READY, 1);
    tick();
    check("t4_issue_io", ISSUE_IO, 1);
    op(K_ALU, 7, 1, 2); #1 check("t4_alu_after_io", DEC_READY, 1);
    tick(); idle();
    check("t4_io_once", ISSUE_IO, 0);
    check("t4_issue_alu", ISSUE_ALU, 1);

    // Flush suppresses issue; reset in DRAIN discards everything.
    op(K_ALU, 8, 1, 2); FLUSH = 1; #1 check("t5_flush_ready", DEC_READY, 0);
    tick(); FLUSH = 0; idle();
    check("t5_no_issue", {ISSUE_IO, ISSUE_FPU, ISSUE_LSU, ISSUE_ALU}, 0);
    op(K_LOAD, 9, 1, 0); tick();
    op(K_IO, 0, 0, 0); tick(); tick();
    RST = 1; tick();
    check("t5_rst_cnt", OUT_CNT, 0);
    check("t5_rst_err", ERR, 0);
    RST = 0;
    op(K_ALU, 1, 2, 3); #1 check("t5_run_after_rst", DEC_READY, 1);
    tick(); idle();

    // Stray writeback sets sticky ERR; x0 load counted but never busy.
    wb(0, 4); tick(); nowb();
    check("t6_err_set", ERR, 1);
    tick(); tick();
    check("t6_err_sticky", ERR, 1);
    check("t6_cnt_hold", OUT_CNT, 0);
    op(K_LOAD, 0, 1, 0); tick();
    check("t6_x0_counted", OUT_CNT, 1);
    op(K_ALU, 1, 0, 0); #1 check("t6_x0_not_busy", DEC_READY, 1);
    tick(); idle();

    // Randomized traffic.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int k, sel;
      if (m_drain) k = K_IO;
      else begin
        sel = $urandom_range(0, 19);
        k = (sel < 6) ? K_ALU : (sel < 9) ? K_BR : (sel < 13) ? K_LOAD :
            (sel < 15) ? K_STORE : (sel < 19) ? K_FPU : K_IO;
      end
      op(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (!m_drain && $urandom_range(0, 4) == 0) DEC_VALID = 0;
      LSU_READY = ($urandom_range(0, 3) != 0);
      FPU_READY = ($urandom_range(0, 3) != 0);
      FLUSH     = ($urandom_range(0, 11) == 0);
      nowb();
      if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        int j;
        j = $urandom_range(0, m_q.size() - 1);
        wb(m_q[j].fp, m_q[j].rd);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/core_issue_ctrl.md
Name: core_issue_ctrl

Overview:
Issue controller between core_decode and the execution units (ALU, LSU, FPU, IO). Holds a register scoreboard for long-latency results (loads, FPU ops) and stalls decode on RAW/WAW hazards or a busy unit. Serializes IN/OUT instructions by draining outstanding work first. Handles branch-resolution flushes.

Parameters:
NUM_REGS, 32, registers per file (integer and FP scoreboards each)
MAX_OUT, 4, maximum outstanding long-latency writebacks
CNT_W, 3, outstanding-counter width (must hold MAX_OUT)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
DEC_VALID  in  1  decoded instruction present
DEC_READY  out  1  controller accepts instruction this cycle (combinational)
RD_NUM  in  5  destination register
RS1_NUM  in  5  source 1
RS2_NUM  in  5  source 2
RD_FP, RS1_FP, RS2_FP  in  1 each  operand selects FP file
CLS_ALU, CLS_BR, CLS_LOAD, CLS_STORE, CLS_FPU, CLS_IO  in  1 each  one-hot class
LSU_READY  in  1  LSU can accept
FPU_READY  in  1  FPU can accept
WB_VALID  in  1  long-latency writeback
WB_RD  in  5  writeback register
WB_FP  in  1  writeback targets FP file
FLUSH  in  1  branch mispredict/redirect
ISSUE_ALU, ISSUE_LSU, ISSUE_FPU, ISSUE_IO  out  1 each  registered one-cycle issue pulses
ISSUE_RD  out  5  registered rd of issued instruction
OUT_CNT  out  CNT_W  outstanding long-latency count
ERR  out  1  sticky: writeback to non-busy register, or counter underflow

Behaviour:
- Reset: all ISSUE_* = 0, ISSUE_RD = 0, OUT_CNT = 0, ERR = 0, both scoreboards clear, FSM = RUN. Reset mid-stall discards everything.
- Busy test: int reg busy = sb_int[n] && !(WB_VALID && !WB_FP && WB_RD==n); FP likewise. Same-cycle writeback bypasses the check. Int x0 never busy.
- hazard = busy(RS1) || busy(RS2) || busy(RD) for classes that use each operand: STORE/BR use RS1/RS2 and no RD; LOAD uses RS1 and RD.
- unit_ok: LOAD/STORE need LSU_READY; FPU needs FPU_READY; ALU/BR always ok.
- DEC_READY = state==RUN && !FLUSH && !hazard && unit_ok && !(long op && OUT_CNT==MAX_OUT) && !CLS_IO. In DRAIN, DEC_READY = (OUT_CNT==0) && !FLUSH.
- Accept = DEC_VALID && DEC_READY. Cycle N+1: exactly one ISSUE_* pulses for one cycle and ISSUE_RD = RD_NUM. Otherwise all ISSUE_* are 0.
- Long op = LOAD, or FPU with rd. On accept, set sb[RD] and increment OUT_CNT. Int rd=0 sets no bit but is still counted.
- WB_VALID clears sb[WB_RD] and decrements OUT_CNT. Same cycle as an accept: a set of the same register wins over the clear, and the counter nets to zero.
- WB_VALID with OUT_CNT==0 or a non-busy target: set ERR, counter holds at 0.
- FSM:
  - RUN -> DRAIN when DEC_VALID && CLS_IO && !FLUSH.
  - DRAIN accepts the IO op once OUT_CNT==0 (ISSUE_IO next cycle), then -> RUN.
  - FLUSH in any state -> RUN; no accept that cycle.
  - ISSUE_* are suppressed in the cycle after FLUSH. Already-issued scoreboard entries stay until their writeback.

Decomposition:
- Shared package core_pkg holds the instruction-class encoding constants, the REG_W=5 constant, and the FSM state encoding (RUN, DRAIN).
- One sub-module, core_scoreboard: NUM_REGS-bit set/clear vector with the bypassed busy lookup, instantiated once for the integer file and once for the FP file.

Test Plan:
- Load x5, then ADD x6,x5,x1 back-to-back -> DEC_READY=0 until WB_VALID WB_RD=5; accept in the same WB cycle, ISSUE_ALU the next cycle.
- FPU op f3, then FLW f3 while FPU_READY=1 -> WAW stall; the FP file is used (an int x3 writeback must not release it).
- Four loads with no writeback -> OUT_CNT=4 and a fifth load stalls; one WB gives OUT_CNT=3, then the fifth issues.
- OUT with OUT_CNT=2 -> DRAIN, DEC_READY=0 until two WBs; ISSUE_IO pulses once; ALU op accepted the following cycle.
- FLUSH with DEC_VALID and no hazard -> no ISSUE_* next cycle; RST asserted in DRAIN -> OUT_CNT=0, FSM=RUN, ERR=0.
- WB_VALID with OUT_CNT=0 -> ERR=1 and stays sticky; load x0 -> OUT_CNT increments but a following ADD using x0 does not stall.
